// File: rtl/fx_bus_master.sv
// fx_bus_master: host command-stream to fx register bus bridge.
// Decodes write/read packets into fx strobes and returns read bytes.
module fx_bus_master #(
  parameter int TO_CYC = 50000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  output logic [7:0]  rsp_data,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic [21:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic        err_pulse
);

  typedef enum logic [3:0] {
    IDLE, ADR2, ADR1, ADR0, LEN,
    WDAT, WSTB, RSTB, RCAP, RSND
  } state_t;

  localparam logic [7:0]  OP_WR  = 8'h57;
  localparam logic [7:0]  OP_RD  = 8'h52;
  localparam logic [15:0] TO_LIM = 16'(TO_CYC - 1);

  state_t      state, state_nx;
  logic        op_wr;
  logic [5:0]  dev;
  logic [15:0] addr;
  logic [8:0]  cnt;
  logic [15:0] to_cnt;
  logic        acc, last, timing, err_nx;

  assign acc  = cmd_vld & cmd_rdy;
  assign last = (cnt == 9'd1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: if (acc) begin
        if (cmd_data == OP_WR || cmd_data == OP_RD)
          state_nx = ADR2;
        else
          err_nx = 1'b1;
      end
      ADR2: if (acc) state_nx = ADR1;
      ADR1: if (acc) state_nx = ADR0;
      ADR0: if (acc) state_nx = LEN;
      LEN:  if (acc) state_nx = op_wr ? WDAT : RSTB;
      WDAT: if (acc) state_nx = WSTB;
      WSTB: state_nx = last ? IDLE : WDAT;
      RSTB: state_nx = RCAP;
      RCAP: state_nx = RSND;
      RSND: if (rsp_rdy) state_nx = last ? IDLE : RSTB;
      default: state_nx = IDLE;
    endcase
    // inter-byte stall inside a packet aborts it
    if (timing && !acc && to_cnt == TO_LIM) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end
  end

  always_comb begin
    cmd_rdy = 1'b0;
    busy    = 1'b1;
    timing  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
      end
      ADR2, ADR1, ADR0, LEN, WDAT: begin
        cmd_rdy = 1'b1;
        timing  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      op_wr     <= 1'b0;
      dev       <= '0;
      addr      <= '0;
      cnt       <= '0;
      to_cnt    <= '0;
      fx_waddr  <= '0;
      fx_raddr  <= '0;
      fx_data   <= '0;
      fx_wr     <= 1'b0;
      fx_rd     <= 1'b0;
      rsp_data  <= '0;
      rsp_vld   <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      fx_wr     <= (state_nx == WSTB);
      fx_rd     <= (state_nx == RSTB);
      err_pulse <= err_nx;
      if (acc || !timing) to_cnt <= '0;
      else                to_cnt <= to_cnt + 16'd1;
      if (acc) begin
        unique case (state)
          IDLE: op_wr <= (cmd_data == OP_WR);
          ADR2: dev <= cmd_data[5:0];
          ADR1: addr[15:8] <= cmd_data;
          ADR0: addr[7:0] <= cmd_data;
          LEN:  cnt <= {cmd_data == 8'd0, cmd_data};
          WDAT: begin
            fx_data  <= cmd_data;
            fx_waddr <= {dev, addr};
          end
          default: ;
        endcase
      end
      if (state == WSTB) begin
        addr <= addr + 16'd1;
        cnt  <= cnt - 9'd1;
      end
      // next read address already includes the post-handshake increment
      if (state_nx == RSTB)
        fx_raddr <= {dev, (state == RSND) ? addr + 16'd1 : addr};
      if (state == RCAP) begin
        rsp_data <= fx_q;
        rsp_vld  <= 1'b1;
      end
      if (state == RSND && rsp_rdy) begin
        rsp_vld <= 1'b0;
        addr    <= addr + 16'd1;
        cnt     <= cnt - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_fx_bus_master.sv
// tb_fx_bus_master: directed and randomized packets checked
// against a transaction-level model of expected fx and rsp traffic.
module tb_fx_bus_master;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_data = '0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [7:0]  rsp_data;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q = '0;
  logic        busy;
  logic        err_pulse;

  fx_bus_master #(.TO_CYC(8)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
    .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  logic [29:0] exp_w[$];
  logic [21:0] exp_ra[$];
  logic [7:0]  exp_rs[$];
  int err_seen = 0;
  int err_exp = 0;
  int overlap = 0;
  int nwr = 0;
  int nrd = 0;
  bit rsp_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slv(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  // stub slave: data one cycle after the read strobe, 0 otherwise
  always @(posedge clk_sys) fx_q <= fx_rd ? slv(fx_raddr) : 8'h00;

  initial forever begin
    @(posedge clk_sys);
    #1;
    rsp_rdy = rsp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk_sys) if (rst_n === 1'b1) begin
    if (fx_wr) begin
      nwr++;
      if (exp_w.size() == 0) chk("wr_unexp", 1, 0);
      else chk("wr", {fx_waddr, fx_data}, exp_w.pop_front());
    end
    if (fx_rd) begin
      nrd++;
      if (exp_ra.size() == 0) chk("rd_unexp", 1, 0);
      else chk("rd", fx_raddr, exp_ra.pop_front());
    end
    if (rsp_vld && rsp_rdy) begin
      if (exp_rs.size() == 0) chk("rsp_unexp", 1, 0);
      else chk("rsp", rsp_data, exp_rs.pop_front());
    end
    if (fx_wr && fx_rd) overlap++;
    if (err_pulse) err_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bit ok;
    cmd_vld = 1'b0;
    cyc(gap);
    cmd_data = b;
    cmd_vld  = 1'b1;
    n = 0;
    do begin
      @(negedge clk_sys);
      ok = cmd_rdy;
      @(posedge clk_sys);
      #1;
      n++;
    end while (!ok && n < 5000);
    if (!ok) chk("cmd_rdy_wait", 0, 1);
    cmd_vld = 1'b0;
  endtask

  task automatic send_pkt(input bit wr, input logic [5:0] dev,
                          input logic [15:0] a, input logic [7:0] len,
                          input logic [7:0] d0, input int gmax);
    int n;
    logic [15:0] p;
    logic [1:0] hi;
    n  = (len == 8'd0) ? 256 : int'(len);
    hi = 2'($urandom_range(0, 3));
    p  = a;
    for (int i = 0; i < n; i++) begin
      if (wr) begin
        exp_w.push_back({dev, p, d0 + 8'(17 * i)});
      end else begin
        exp_ra.push_back({dev, p});
        exp_rs.push_back(slv({dev, p}));
      end
      p = p + 16'd1;
    end
    send_byte(wr ? 8'h57 : 8'h52, $urandom_range(0, gmax));
    send_byte({hi, dev}, $urandom_range(0, gmax));
    send_byte(a[15:8], $urandom_range(0, gmax));
    send_byte(a[7:0], $urandom_range(0, gmax));
    send_byte(len, $urandom_range(0, gmax));
    if (wr)
      for (int i = 0; i < n; i++)
        send_byte(d0 + 8'(17 * i), $urandom_range(0, gmax));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    cyc(2);
    while (busy && n < 5000) begin
      cyc(1);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    int base;
    logic [7:0] hold_d;
    bit hold_ok;
    int n;
    logic [7:0] b;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cyc(3);
    #1;
    chk("rst_wa", fx_waddr, 0);
    chk("rst_ra", fx_raddr, 0);
    chk("rst_misc", {fx_wr, fx_rd, rsp_vld, err_pulse, busy,
                     fx_data, rsp_data}, 0);
    chk("rst_rdy", cmd_rdy, 1);
    rst_n = 1'b1;
    cyc(2);

    // single write
    base = nwr;
    send_pkt(1'b1, 6'h05, 16'h0022, 8'd1, 8'hAB, 0);
    cyc(1);
    chk("w1_busy", busy, 0);
    chk("w1_rdy", cmd_rdy, 1);
    chk("w1_nwr", nwr - base, 1);

    // single read
    base = nrd;
    send_pkt(1'b0, 6'h05, 16'h0080, 8'd1, 8'h00, 0);
    wait_idle();
    chk("r1_nrd", nrd - base, 1);

    // burst write across the 16-bit wrap
    base = nwr;
    send_pkt(1'b1, 6'h05, 16'hFFFF, 8'd3, 8'h11, 1);
    wait_idle();
    chk("w3_nwr", nwr - base, 3);

    // read backpressure
    rsp_hold = 1'b1;
    cyc(2);
    base = nrd;
    send_pkt(1'b0, 6'h05, 16'h12F0, 8'd2, 8'h00, 0);
    n = 0;
    while (!rsp_vld && n < 100) begin
      @(posedge clk_sys);
      #2;
      n++;
    end
    chk("bp_vld", rsp_vld, 1);
    hold_d  = rsp_data;
    hold_ok = 1'b1;
    repeat (20) begin
      @(posedge clk_sys);
      #2;
      if (!rsp_vld || rsp_data !== hold_d || nrd - base != 1)
        hold_ok = 1'b0;
    end
    chk("bp_hold", hold_ok, 1);
    chk("bp_data", hold_d, slv(22'h0512F0));
    rsp_hold = 1'b0;
    wait_idle();
    chk("bp_nrd", nrd - base, 2);

    // bad opcode, then a stalled header
    send_byte(8'h13, 0);
    err_exp++;
    cyc(3);
    chk("badop_err", err_seen, err_exp);
    chk("badop_idle", busy, 0);
    base = nwr;
    send_byte(8'h57, 0);
    send_byte(8'h05, 0);
    cyc(6);
    chk("to_early", busy, 1);
    cyc(6);
    err_exp++;
    chk("to_err", err_seen, err_exp);
    chk("to_idle", busy, 0);
    chk("to_nwr", nwr - base, 0);

    // reset in the middle of a 4-byte write burst
    base = nwr;
    exp_w.push_back({6'h05, 16'h0010, 8'hAA});
    send_byte(8'h57, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h04, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    #2;
    chk("mr_wa", fx_waddr, 0);
    chk("mr_misc", {fx_wr, fx_rd, rsp_vld, err_pulse, busy,
                    fx_data, rsp_data}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    chk("mr_nwr", nwr - base, 1);
    chk("mr_idle", busy, 0);

    // randomized packets
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        send_byte(b, $urandom_range(0, 2));
        err_exp++;
      end
      send_pkt($urandom_range(0, 1) == 1, 6'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
               ($urandom_range(0, 15) == 0) ? 8'd0
                 : 8'($urandom_range(1, 5)),
               8'($urandom), 2);
    end
    wait_idle();
    cyc(4);
    chk("err_cnt", err_seen, err_exp);
    chk("w_left", exp_w.size(), 0);
    chk("ra_left", exp_ra.size(), 0);
    chk("rs_left", exp_rs.size(), 0);
    chk("wr_rd_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fx_bus_master.md
Name: fx_bus_master

Overview:
- Command-stream to fx-bus bridge. Accepts host command bytes from the USB FIFO side and drives fx_waddr/fx_wr/fx_data and fx_raddr/fx_rd to the register slaves.
- Collects read data from fx_q and returns it as a response byte stream.
- Sits in chip_top between the host interface and every block with an fx register slave. fx_q is the OR of all slave fx_q outputs; an unselected slave drives 0.

Parameters:
- TO_CYC, 50000, idle cycles allowed between bytes inside a packet before abort (16-bit, must be >= 2).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_data  in  8  command byte
- cmd_vld  in  1  cmd_data valid
- cmd_rdy  out  1  bridge accepts byte; transfer when cmd_vld & cmd_rdy
- rsp_data  out  8  read response byte
- rsp_vld  out  1  rsp_data valid
- rsp_rdy  in  1  host accepts response; transfer when rsp_vld & rsp_rdy
- fx_waddr  out  22  write address: [21:16] dev_id, [15:0] register
- fx_wr  out  1  one-cycle write strobe
- fx_data  out  8  write data
- fx_raddr  out  22  read address
- fx_rd  out  1  one-cycle read strobe
- fx_q  in  8  OR-combined slave read data; valid the cycle after fx_rd
- busy  out  1  state != IDLE
- err_pulse  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:

Reset:
- All registered outputs are 0: fx_waddr, fx_raddr, fx_data, fx_wr, fx_rd, rsp_data, rsp_vld, err_pulse.
- State = IDLE.
- cmd_rdy is decoded from state, so it is 1 after reset.
- Reset mid-packet discards the packet. No fx strobe is issued after reset deassertion until a new complete header is received.

Packet format, bytes in order:
- OP: 0x57 = write, 0x52 = read.
- A2: address[21:16]; bits [7:6] are ignored.
- A1: address[15:8].
- A0: address[7:0].
- LEN: 1..255 transfers; 0 means 256.
- Write only: LEN data bytes follow.

States: IDLE, ADR2, ADR1, ADR0, LEN, WDAT, WSTB, RSTB, RCAP, RSND.
- cmd_rdy = 1 in IDLE, ADR2, ADR1, ADR0, LEN, WDAT; 0 otherwise.
- IDLE: accepted 0x57 or 0x52 latches the op and goes to ADR2. Any other byte: err_pulse, stay IDLE.
- ADR2 / ADR1 / ADR0 / LEN: each accepted byte is latched and advances the state. After LEN, a write goes to WDAT and a read goes to RSTB.
- WDAT: an accepted byte loads fx_data and fx_waddr = {dev, addr}, then goes to WSTB.
- WSTB: fx_wr = 1 for exactly this cycle.
  - addr[15:0] increments and wraps 0xFFFF -> 0x0000; dev bits [21:16] never change.
  - Remaining count decrements. If zero, go to IDLE; else go to WDAT.
  - Throughput is at most one write per 2 cycles.
- RSTB: fx_raddr = {dev, addr}, fx_rd = 1 for exactly this cycle. Go to RCAP.
- RCAP: rsp_data <= fx_q, rsp_vld <= 1. Go to RSND.
- RSND: hold rsp_data and rsp_vld until rsp_rdy.
  - On handshake, rsp_vld drops in the same edge, addr increments with the same wrap rule, and count decrements.
  - If count is zero, go to IDLE; else go to RSTB.
  - No timeout applies in RSND; host backpressure may be unbounded.
- fx_waddr, fx_raddr and fx_data hold their last value between strobes. fx_wr and fx_rd are never asserted in the same cycle.

Timeout:
- A 16-bit counter clears on every accepted cmd byte and on entry to ADR2.
- It counts in ADR2, ADR1, ADR0, LEN and WDAT.
- At TO_CYC-1 the bridge emits err_pulse and goes to IDLE. No strobe is issued for the unreceived byte; writes already issued stand.

Test Plan:
1. Single write: send 57 05 00 22 01 AB -> exactly one cycle with fx_wr=1, fx_waddr=0x050022, fx_data=0xAB. Then busy=0 and cmd_rdy=1.
2. Single read with a stub slave returning 0x5A one cycle after fx_rd: send 52 05 00 80 01 -> one fx_rd with fx_raddr=0x050080, then rsp_vld=1 with rsp_data=0x5A. Nothing else is output.
3. Burst write with wrap: send 57 05 FF FF 03 11 22 33 -> three fx_wr pulses at 0x05FFFF, 0x050000, 0x050001 with data 11, 22, 33.
4. Read backpressure: LEN=2 with rsp_rdy held 0 for 20 cycles -> rsp_data is stable and rsp_vld stays 1, with no second fx_rd before the first handshake. Exactly 2 fx_rd in total.
5. Bad opcode / timeout (TO_CYC=8): byte 0x13 -> err_pulse, stay IDLE. Then 57 05 stalls for 8 cycles -> err_pulse, IDLE, no fx_wr.
6. Reset mid-burst: assert rst_n=0 after the 2nd of 4 write bytes -> outputs are 0 immediately, and after release there is no fx_wr without a new packet.
